// File: rtl/fft_pkg.sv
// Shared definitions for the butterfly stage and its output serializer.
package fft_pkg;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_NUM   = 16;
  localparam int unsigned DEF_HALF  = 16;

  // One signed lane sample at the default width.
  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic {
    S_PASS  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Counter width; a depth of one still needs a 1-bit address.
  function automatic int unsigned cnt_width(input int unsigned half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/bfly_out_serializer_if.sv
// Butterfly-output / serialised-stream bundle between the butterfly stage and the next stage.
interface bfly_out_serializer_if
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NUM   = DEF_NUM
) ();

  logic                    valid_in;
  logic                    in_ready;
  logic signed [WIDTH-1:0] do1_re  [NUM];
  logic signed [WIDTH-1:0] do1_im  [NUM];
  logic signed [WIDTH-1:0] do2_re  [NUM];
  logic signed [WIDTH-1:0] do2_im  [NUM];
  logic signed [WIDTH-1:0] dout_re [NUM];
  logic signed [WIDTH-1:0] dout_im [NUM];
  logic                    valid_out;
  logic                    sof;
  logic                    eof;

  // Upstream producer / downstream observer side.
  modport master (
    output valid_in, do1_re, do1_im, do2_re, do2_im,
    input  in_ready, dout_re, dout_im, valid_out, sof, eof
  );

  // Serializer side.
  modport slave (
    input  valid_in, do1_re, do1_im, do2_re, do2_im,
    output in_ready, dout_re, dout_im, valid_out, sof, eof
  );

endinterface

// File: rtl/bfly_out_serializer_lane_buffer.sv
// HALF-deep store of do2 beats: synchronous write, combinational read, no reset.
module lane_buffer #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned NUM   = 16,
  parameter int unsigned HALF  = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic signed [WIDTH-1:0] i_wdata_re [NUM],
  input  logic signed [WIDTH-1:0] i_wdata_im [NUM],
  input  logic [AW-1:0]           i_raddr,
  output logic signed [WIDTH-1:0] o_rdata_re [NUM],
  output logic signed [WIDTH-1:0] o_rdata_im [NUM]
);

  logic signed [WIDTH-1:0] r_mem_re [HALF][NUM];
  logic signed [WIDTH-1:0] r_mem_im [HALF][NUM];

  // Store one full beat (all lanes, re and im) per write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_re[i_waddr] <= i_wdata_re;
      r_mem_im[i_waddr] <= i_wdata_im;
    end
  end

  assign o_rdata_re = r_mem_re[i_raddr];
  assign o_rdata_im = r_mem_im[i_raddr];

endmodule

// File: rtl/bfly_out_serializer.sv
// Re-serialises butterfly do1/do2 beats: do1 passes through, do2 is buffered then drained.
module bfly_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NUM   = DEF_NUM,
  parameter int unsigned HALF  = DEF_HALF
) (
  input  logic                 clk,
  input  logic                 rstn,
  bfly_out_serializer_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(HALF);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF - 1);

  state_e                  r_state, w_state_d;
  logic [CntW-1:0]         r_cnt, w_cnt_d;
  logic                    w_last;
  logic                    w_we;
  logic                    r_valid, w_valid_d;
  logic                    r_sof, w_sof_d;
  logic                    r_eof, w_eof_d;
  logic signed [WIDTH-1:0] r_dout_re [NUM];
  logic signed [WIDTH-1:0] r_dout_im [NUM];
  logic signed [WIDTH-1:0] w_dout_re_d [NUM];
  logic signed [WIDTH-1:0] w_dout_im_d [NUM];
  logic signed [WIDTH-1:0] w_rd_re [NUM];
  logic signed [WIDTH-1:0] w_rd_im [NUM];

  // Write and read share the counter; they occur in different states.
  lane_buffer #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .HALF  (HALF),
    .AW    (CntW)
  ) u_lane_buffer (
    .clk        (clk),
    .i_we       (w_we),
    .i_waddr    (r_cnt),
    .i_wdata_re (bus.do2_re),
    .i_wdata_im (bus.do2_im),
    .i_raddr    (r_cnt),
    .o_rdata_re (w_rd_re),
    .o_rdata_im (w_rd_im)
  );

  assign w_last       = (r_cnt == CntLast);
  assign bus.in_ready = (r_state == S_PASS);

  // Next state, counter and output values; dout holds when nothing is emitted.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_valid_d   = 1'b0;
    w_sof_d     = 1'b0;
    w_eof_d     = 1'b0;
    w_we        = 1'b0;
    w_dout_re_d = r_dout_re;
    w_dout_im_d = r_dout_im;
    unique case (r_state)
      S_PASS: begin
        if (bus.valid_in) begin
          w_dout_re_d = bus.do1_re;
          w_dout_im_d = bus.do1_im;
          w_valid_d   = 1'b1;
          w_sof_d     = (r_cnt == '0);
          w_we        = 1'b1;
          if (w_last) begin
            w_cnt_d   = '0;
            w_state_d = S_DRAIN;
          end else begin
            w_cnt_d   = r_cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        w_dout_re_d = w_rd_re;
        w_dout_im_d = w_rd_im;
        w_valid_d   = 1'b1;
        w_eof_d     = w_last;
        if (w_last) begin
          w_cnt_d   = '0;
          w_state_d = S_PASS;
        end else begin
          w_cnt_d   = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_PASS;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_dout_re <= '{default: '0};
      r_dout_im <= '{default: '0};
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_valid   <= w_valid_d;
      r_sof     <= w_sof_d;
      r_eof     <= w_eof_d;
      r_dout_re <= w_dout_re_d;
      r_dout_im <= w_dout_im_d;
    end
  end

  assign bus.dout_re   = r_dout_re;
  assign bus.dout_im   = r_dout_im;
  assign bus.valid_out = r_valid;
  assign bus.sof       = r_sof;
  assign bus.eof       = r_eof;

endmodule

// File: tb/tb_bfly_out_serializer.sv
// Directed, table-driven bench for bfly_out_serializer (HALF=16 and HALF=1 instances).
module tb_bfly_out_serializer;
  import fft_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int N = DEF_NUM;
  localparam int H = DEF_HALF;

  typedef sample_t lanes_t [N];

  // Data kinds: 0 zero, 1 do1 ramp, 2 do2 ramp, 3 do1 extreme, 4 do2 extreme.
  typedef struct {
    bit vin;
    int dsel;
    int dk;
    bit e_rdy;
    bit e_vo;
    bit e_sof;
    bit e_eof;
    int e_kind;
    int e_k;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  bfly_out_serializer_if #(.WIDTH(W), .NUM(N)) bus ();
  bfly_out_serializer_if #(.WIDTH(W), .NUM(N)) bus1 ();

  bfly_out_serializer #(.WIDTH(W), .NUM(N), .HALF(H)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  bfly_out_serializer #(.WIDTH(W), .NUM(N), .HALF(1)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  function automatic int exp_re(int kind, int k, int l);
    case (kind)
      1:       return k + 16 * l;
      2:       return 100 + k + 16 * l;
      3:       return (l % 2 == 0) ? -512 : 511;
      4:       return (l % 2 == 0) ? 511 : -512;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_im(int kind, int k, int l);
    case (kind)
      1:       return -(k + 16 * l);
      2:       return -(100 + k + 16 * l);
      3:       return (l % 2 == 0) ? 511 : -512;
      4:       return (l % 2 == 0) ? -512 : 511;
      default: return 0;
    endcase
  endfunction

  function automatic vec_t mk(bit vin, int dsel, int dk, bit rdy, bit vo, bit sof, bit eof,
                              int kind, int k);
    vec_t v;
    v.vin = vin; v.dsel = dsel; v.dk = dk;
    v.e_rdy = rdy; v.e_vo = vo; v.e_sof = sof; v.e_eof = eof;
    v.e_kind = kind; v.e_k = k;
    return v;
  endfunction

  task automatic chk(string nm, int idx, int got, int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      if (n_bad < 60) $display("FAIL %s @%0d: got %0d, expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic check_vals(string nm, int idx, logic rdy, logic vo, logic sof, logic eof,
                            input lanes_t re, input lanes_t im, input vec_t e);
    chk({nm, ".in_ready"}, idx, int'(rdy), int'(e.e_rdy));
    chk({nm, ".valid_out"}, idx, int'(vo), int'(e.e_vo));
    chk({nm, ".sof"}, idx, int'(sof), int'(e.e_sof));
    chk({nm, ".eof"}, idx, int'(eof), int'(e.e_eof));
    for (int l = 0; l < N; l++) begin
      int g;
      g = re[l];
      chk($sformatf("%s.re[%0d]", nm, l), idx, g, exp_re(e.e_kind, e.e_k, l));
      g = im[l];
      chk($sformatf("%s.im[%0d]", nm, l), idx, g, exp_im(e.e_kind, e.e_k, l));
    end
  endtask

  task automatic drive_main(bit vin, int dsel, int k);
    bus.valid_in = vin;
    for (int l = 0; l < N; l++) begin
      bus.do1_re[l] = sample_t'(exp_re(dsel ? 3 : 1, k, l));
      bus.do1_im[l] = sample_t'(exp_im(dsel ? 3 : 1, k, l));
      bus.do2_re[l] = sample_t'(exp_re(dsel ? 4 : 2, k, l));
      bus.do2_im[l] = sample_t'(exp_im(dsel ? 4 : 2, k, l));
    end
  endtask

  task automatic drive_b1(bit vin, int k);
    bus1.valid_in = vin;
    for (int l = 0; l < N; l++) begin
      bus1.do1_re[l] = sample_t'(exp_re(1, k, l));
      bus1.do1_im[l] = sample_t'(exp_im(1, k, l));
      bus1.do2_re[l] = sample_t'(exp_re(2, k, l));
      bus1.do2_im[l] = sample_t'(exp_im(2, k, l));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive_main(1'b0, 0, 0);
    drive_b1(1'b0, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Each vector: check outputs left by the previous edge, then drive the next inputs.
  task automatic run_vectors(string nm);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      check_vals(nm, i, bus.in_ready, bus.valid_out, bus.sof, bus.eof, bus.dout_re,
                 bus.dout_im, vq[i]);
      drive_main(vq[i].vin, vq[i].dsel, vq[i].dk);
    end
  endtask

  task automatic build_frame(int dsel);
    vq.delete();
    for (int c = 0; c < 34; c++) begin
      bit rdy;
      rdy = (c < 16) || (c >= 32);
      if (c == 0)       vq.push_back(mk(1, dsel, 0, rdy, 0, 0, 0, 0, 0));
      else if (c <= 16) vq.push_back(mk(c < 16, dsel, (c < 16) ? c : 0, rdy, 1, c == 1, 0,
                                         dsel ? 3 : 1, c - 1));
      else if (c <= 32) vq.push_back(mk(0, dsel, 0, rdy, 1, 0, c == 32, dsel ? 4 : 2, c - 17));
      else              vq.push_back(mk(0, dsel, 0, rdy, 0, 0, 0, dsel ? 4 : 2, 15));
    end
  endtask

  initial begin
    lanes_t z;
    vec_t   e;
    drive_main(1'b0, 0, 0);
    drive_b1(1'b0, 0);
    z = '{default: '0};

    // Idle after reset.
    do_reset();
    vq.delete();
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_vectors("idle");

    // One full frame with ramp data.
    do_reset();
    build_frame(0);
    run_vectors("frame");

    // Sign/width extremes.
    do_reset();
    build_frame(1);
    run_vectors("extreme");

    // Gapped pass phase, valid held through drain.
    do_reset();
    vq.delete();
    for (int v = 0; v <= 48; v++) begin
      bit vin, rdy, vo, sof, eof;
      int dk, kind, k;
      vin = (v <= 30) ? (v % 2 == 0) : (v <= 47);
      dk  = (v <= 30) ? v / 2 : 50;
      rdy = (v <= 30) || (v >= 47);
      vo = 1; sof = 0; eof = 0; kind = 1; k = 0;
      if (v == 0) begin
        vo = 0; kind = 0;
      end else if (v <= 31) begin
        if (v % 2 == 1) begin
          k = (v - 1) / 2; sof = (k == 0);
        end else begin
          vo = 0; k = v / 2 - 1;
        end
      end else if (v <= 47) begin
        kind = 2; k = v - 32; eof = (v == 47);
      end else begin
        sof = 1; k = 50;
      end
      vq.push_back(mk(vin, 0, dk, rdy, vo, sof, eof, kind, k));
    end
    run_vectors("gapped");

    // Back-to-back frames with valid held high.
    do_reset();
    vq.delete();
    for (int v = 0; v <= 64; v++) begin
      int p, q;
      p = v % 32;
      if (v == 0) vq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      else begin
        q = (v - 1) % 32;
        if (q < 16) vq.push_back(mk(1, 0, (p < 16) ? p : 0, p < 16, 1, q == 0, 0, 1, q));
        else        vq.push_back(mk(1, 0, (p < 16) ? p : 0, p < 16, 1, 0, q == 31, 2, q - 16));
      end
    end
    run_vectors("b2b");

    // Reset asserted at pass beat 5, then a fresh frame.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      drive_main(1'b1, 0, j);
    end
    @(negedge clk);
    e = mk(0, 0, 0, 1, 1, 0, 0, 1, 4);
    check_vals("midrst.pre", 0, bus.in_ready, bus.valid_out, bus.sof, bus.eof, bus.dout_re,
               bus.dout_im, e);
    drive_main(1'b1, 0, 5);
    #2;
    rstn = 1'b0;
    #1;
    e = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check_vals("midrst.async", 0, bus.in_ready, bus.valid_out, bus.sof, bus.eof, bus.dout_re,
               bus.dout_im, e);
    @(negedge clk);
    rstn = 1'b1;
    drive_main(1'b0, 0, 0);
    build_frame(0);
    run_vectors("midrst.frame");

    // HALF=1 instance: pass beat then drain beat, then a back-to-back frame.
    do_reset();
    @(negedge clk);
    check_vals("h1", 0, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    drive_b1(1'b1, 7);
    @(negedge clk);
    check_vals("h1", 1, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 0, 1, 1, 0, 1, 7));
    drive_b1(1'b1, 8);
    @(negedge clk);
    check_vals("h1", 2, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 1, 1, 0, 1, 2, 7));
    drive_b1(1'b1, 8);
    @(negedge clk);
    check_vals("h1", 3, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 0, 1, 1, 0, 1, 8));
    drive_b1(1'b0, 0);
    @(negedge clk);
    check_vals("h1", 4, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 1, 1, 0, 1, 2, 8));
    @(negedge clk);
    check_vals("h1", 5, bus1.in_ready, bus1.valid_out, bus1.sof, bus1.eof, bus1.dout_re,
               bus1.dout_im, mk(0, 0, 0, 1, 0, 0, 0, 2, 8));

    // Main instance stayed idle throughout the HALF=1 sequence.
    check_vals("h1.main_idle", 0, bus.in_ready, bus.valid_out, bus.sof, bus.eof, bus.dout_re,
               bus.dout_im, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    if (z[0] != 0) $display("unexpected zero-array content");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
